bcd_onehot_decoder: RTL and testbench
=====================================

BCD_ONEHOT_DECODER -- requirements
Module: bcd_onehot_decoder

Interface
REQ-001 Parameter N_OUT, 23, number of one-hot output lines; legal range 2..1000, and N_OUT SHALL be no greater than 10**DIGITS.
REQ-002 Parameter DIGITS, 2, maximum BCD digits per code; legal range 1..3.
REQ-003 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-004 reset_n  input  1  synchronous active-low reset.
REQ-005 digit_valid  input  1  a BCD digit is presented this cycle.
REQ-006 digit  input  4  BCD digit, most significant digit first.
REQ-007 commit  input  1  end of code; requests decode of the accumulated value.
REQ-008 clear  input  1  abandons the frame and returns the block to idle.
REQ-009 q  output  N_OUT  registered one-hot result.
REQ-010 q_valid  output  1  q holds a valid decode.
REQ-011 err  output  1  the frame was rejected.
REQ-012 busy  output  1  a frame is being accumulated.

Function
REQ-013 The FSM SHALL have exactly four states: IDLE, ACCUM, DONE and ERR.
REQ-014 IDLE, digit_valid with digit <= 9: acc = digit, cnt = 1, go to ACCUM.
REQ-015 IDLE, digit_valid with digit > 9: go to ERR.
REQ-016 ACCUM, digit_valid with digit <= 9 and cnt < DIGITS: acc = acc*10 + digit, cnt increments, remain in ACCUM.
REQ-017 ACCUM, digit_valid with digit > 9 or cnt == DIGITS: go to ERR, because the digit is illegal or overflows the code.
REQ-018 ACCUM, commit with acc < N_OUT: q = 1 << acc and q_valid = 1 on the next edge, go to DONE; the latency SHALL be 1 cycle.
REQ-019 ACCUM, commit with acc >= N_OUT: go to ERR, with q = 0.
REQ-020 IDLE, commit: go to ERR, because the code is empty.
REQ-021 commit and digit_valid asserted in the same cycle: commit SHALL take priority and the digit SHALL be discarded.
REQ-022 DONE: q and q_valid SHALL hold; commit SHALL be ignored; digit_valid SHALL start a new frame exactly as in IDLE, with q = 0 and q_valid = 0 on the same edge.
REQ-023 ERR: q = 0, q_valid = 0, err = 1.
REQ-024 clear SHALL have priority over all other inputs and force IDLE on the next edge, with q = 0, q_valid = 0, err = 0 and acc/cnt = 0.
REQ-025 busy SHALL be 1 exactly while the FSM is in ACCUM.
REQ-026 acc SHALL be $clog2(10**DIGITS) bits wide, and the multiply-add SHALL be computed at that width without truncation.
REQ-027 At most one bit of q SHALL ever be set.

Reset
REQ-028 When reset_n = 0 at a rising edge, the block SHALL enter IDLE with q = 0, q_valid = 0, err = 0, busy = 0 and acc = cnt = 0.
REQ-029 Reset asserted mid-frame SHALL discard the partial code, with no err or q_valid pulse.

Configuration
REQ-030 The macro BCD_DEC_STICKY_ERR_EN SHALL select the error behaviour.
REQ-031 With BCD_DEC_STICKY_ERR_EN defined: ERR SHALL persist, ignoring digit_valid and commit, until clear or reset.
REQ-032 Without BCD_DEC_STICKY_ERR_EN: ERR SHALL last exactly one cycle, so err is a 1-cycle pulse, and then return to IDLE; digit_valid during ERR SHALL be ignored.

Structure
REQ-033 Package bcd_dec_pkg SHALL hold the FSM state enum typedef, the ACC_W width function and the BCD_MAX = 9 constant.
REQ-034 Sub-module bcd_digit_acc SHALL hold acc, cnt and the overflow and illegal-digit detection; the FSM and the one-hot register SHALL stay in bcd_onehot_decoder.

Verification
REQ-035 Defaults; digits 1, 5 then commit -> next cycle q = 1<<15, q_valid = 1; held until clear.
REQ-036 Digits 2, 2 then commit -> q = 1<<22; digits 2, 3 then commit -> err = 1 and q = 0.
REQ-037 Digit 4'hA in IDLE -> err; without the macro err pulses 1 cycle then IDLE; with the macro err holds until clear.
REQ-038 Digits 1, 2, 3 with DIGITS = 2 -> err on the third digit; commit in the same cycle as a digit -> digit ignored.
REQ-039 In DONE, new digit 7 -> q = 0 and busy = 1; then commit -> q = 1<<7.
REQ-040 reset_n = 0 during ACCUM -> all outputs 0 next cycle, no err; N_OUT = 10, DIGITS = 1: digit 9 then commit -> q = 1<<9.

Source files
------------

// File: rtl/bcd_dec_pkg.sv
// Shared types and constants for the BCD one-hot decoder.
//   state_t : decoder FSM states
//   BCD_MAX : largest legal BCD digit
//   ACC_W() : accumulator width needed to hold any DIGITS-digit decimal code
package bcd_dec_pkg;

  typedef enum logic [1:0] {IDLE, ACCUM, DONE, ERR} state_t;

  localparam logic [3:0] BCD_MAX = 4'd9;

  // $clog2(10**digits), built with a loop so it stays a plain constant function.
  function automatic int ACC_W(input int digits);
    int p;
    p = 1;
    for (int i = 0; i < digits; i++) p = p * 10;
    return $clog2(p);
  endfunction

endpackage

// File: rtl/bcd_onehot_decoder_if.sv
// Handshake bundle between a digit source and the BCD one-hot decoder.
//   master : drives digit_valid/digit/commit/clear, observes results
//   slave  : the decoder side
interface bcd_onehot_decoder_if #(
  parameter int N_OUT = 23
);
  logic             digit_valid;
  logic [3:0]       digit;
  logic             commit;
  logic             clear;
  logic [N_OUT-1:0] q;
  logic             q_valid;
  logic             err;
  logic             busy;

  modport master (
    output digit_valid, digit, commit, clear,
    input  q, q_valid, err, busy
  );

  modport slave (
    input  digit_valid, digit, commit, clear,
    output q, q_valid, err, busy
  );
endinterface

// File: rtl/bcd_digit_acc.sv
// Decimal code accumulator for the BCD decoder.
//   clk, reset_n : clock, synchronous active-low reset
//   clr          : zero acc/cnt (frame abandoned)
//   load         : start a frame with this digit (acc = digit, cnt = 1)
//   push         : append this digit (acc = acc*10 + digit, cnt + 1)
//   digit        : incoming BCD digit
//   acc          : accumulated value, wide enough for DIGITS decimal digits
//   illegal      : current digit is not a BCD digit
//   ovf          : code already holds DIGITS digits, another would overflow
module bcd_digit_acc
  import bcd_dec_pkg::*;
#(
  parameter int  DIGITS = 2,
  localparam int AW     = ACC_W(DIGITS),
  localparam int CW     = $clog2(DIGITS + 1)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          clr,
  input  logic          load,
  input  logic          push,
  input  logic [3:0]    digit,
  output logic [AW-1:0] acc,
  output logic          illegal,
  output logic          ovf
);

  logic [CW-1:0] cnt;

  assign illegal = (digit > BCD_MAX);
  assign ovf     = (cnt == CW'(DIGITS));

  // push is only issued while cnt < DIGITS, so acc < 10**(DIGITS-1) and the
  // multiply-add result always fits in AW bits.
  always_ff @(posedge clk) begin
    if (!reset_n || clr) begin
      acc <= '0;
      cnt <= '0;
    end else if (load) begin
      acc <= AW'(digit);
      cnt <= CW'(1);
    end else if (push) begin
      acc <= acc * AW'(10) + AW'(digit);
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/bcd_onehot_decoder.sv
// BCD code to one-hot decoder.
// Digits arrive MSD first on digit/digit_valid; commit decodes the code into
// a single set bit of q (1-cycle latency). Bad digits, overlong codes, empty
// commits and out-of-range codes land in ERR.
//   clk, reset_n : clock, synchronous active-low reset
//   bus (slave)  : digit_valid, digit, commit, clear in; q, q_valid, err, busy out
// Parameters: N_OUT (2..1000, <= 10**DIGITS) one-hot width, DIGITS (1..3).
// The interface instance must use the same N_OUT.
// Build option: define BCD_DEC_STICKY_ERR_EN to hold ERR until clear/reset;
// otherwise err is a one-cycle pulse followed by IDLE.
module bcd_onehot_decoder
  import bcd_dec_pkg::*;
#(
  parameter int N_OUT  = 23,
  parameter int DIGITS = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  bcd_onehot_decoder_if.slave   bus
);

  localparam int AW = ACC_W(DIGITS);

  state_t           state;
  logic [N_OUT-1:0] q_r;
  logic             q_valid_r, err_r, busy_r;
  logic             acc_clr, acc_load, acc_push;
  logic [AW-1:0]    acc;
  logic             illegal, ovf;

  bcd_digit_acc #(.DIGITS(DIGITS)) u_acc (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (acc_clr),
    .load    (acc_load),
    .push    (acc_push),
    .digit   (bus.digit),
    .acc     (acc),
    .illegal (illegal),
    .ovf     (ovf)
  );

  // Accumulator steering mirrors the FSM: commit wins over a same-cycle digit,
  // so a digit is only taken when commit is low.
  always_comb begin
    acc_clr  = 1'b0;
    acc_load = 1'b0;
    acc_push = 1'b0;
    if (bus.clear) acc_clr = 1'b1;
    else begin
      case (state)
        IDLE, DONE: acc_load = bus.digit_valid && !bus.commit && !illegal;
        ACCUM:      acc_push = bus.digit_valid && !bus.commit && !illegal && !ovf;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n || bus.clear) begin
      state     <= IDLE;
      q_r       <= '0;
      q_valid_r <= 1'b0;
      err_r     <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      case (state)
        // DONE behaves like IDLE except that commit is ignored and the held
        // result stays until a new digit arrives.
        IDLE, DONE: begin
          if (bus.commit) begin
            if (state == IDLE) begin
              state <= ERR;
              err_r <= 1'b1;
            end
          end else if (bus.digit_valid) begin
            q_r       <= '0;
            q_valid_r <= 1'b0;
            if (illegal) begin
              state <= ERR;
              err_r <= 1'b1;
            end else begin
              state  <= ACCUM;
              busy_r <= 1'b1;
            end
          end
        end
        ACCUM: begin
          if (bus.commit) begin
            busy_r <= 1'b0;
            if (int'(acc) < N_OUT) begin
              state     <= DONE;
              q_r       <= N_OUT'(1) << acc;
              q_valid_r <= 1'b1;
            end else begin
              state <= ERR;
              err_r <= 1'b1;
            end
          end else if (bus.digit_valid && (illegal || ovf)) begin
            state  <= ERR;
            err_r  <= 1'b1;
            busy_r <= 1'b0;
          end
        end
        ERR: begin
`ifdef BCD_DEC_STICKY_ERR_EN
          state <= ERR;
`else
          state <= IDLE;
          err_r <= 1'b0;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.q       = q_r;
  assign bus.q_valid = q_valid_r;
  assign bus.err     = err_r;
  assign bus.busy    = busy_r;

endmodule

// File: tb/tb_bcd_onehot_decoder.sv
// Scoreboard bench: two decoders (N_OUT=23/DIGITS=2 and N_OUT=10/DIGITS=1)
// share one stimulus stream; a frame-level model predicts every cycle's
// outputs, and per-DUT monitors pop and compare on the falling edge.
module tb_bcd_onehot_decoder;

`ifdef BCD_DEC_STICKY_ERR_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] q;
    logic        qv;
    logic        err;
    logic        busy;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  bcd_onehot_decoder_if #(.N_OUT(23)) ia ();
  bcd_onehot_decoder_if #(.N_OUT(10)) ib ();

  bcd_onehot_decoder #(.N_OUT(23), .DIGITS(2)) dut_a (.clk(clk), .reset_n(reset_n), .bus(ia));
  bcd_onehot_decoder #(.N_OUT(10), .DIGITS(1)) dut_b (.clk(clk), .reset_n(reset_n), .bus(ib));

  int checks = 0;
  int errors = 0;

  exp_t qa[$];
  exp_t qb[$];
  exp_t ea, eb;

  // Frame-level model: which digits have been seen, what value they spell,
  // which result is on show, whether an error is being reported.
  int nout[2] = '{23, 10};
  int ndig[2] = '{2, 1};
  bit open[2];
  int hold[2];
  bit errf[2];
  int val[2];
  int cnt[2];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step(input int l, input bit rst, input bit dv, input int d,
                      input bit cm, input bit clr);
    if (!rst || clr) begin
      open[l] = 0; hold[l] = -1; errf[l] = 0; val[l] = 0; cnt[l] = 0;
    end else if (errf[l]) begin
      if (!STICKY) errf[l] = 0;
    end else if (open[l]) begin
      if (cm) begin
        open[l] = 0;
        if (val[l] < nout[l]) hold[l] = val[l];
        else errf[l] = 1;
      end else if (dv) begin
        if (d > 9 || cnt[l] == ndig[l]) begin
          open[l] = 0; errf[l] = 1;
        end else begin
          val[l] = val[l] * 10 + d; cnt[l]++;
        end
      end
    end else begin
      if (cm) begin
        if (hold[l] < 0) errf[l] = 1;
      end else if (dv) begin
        hold[l] = -1;
        if (d > 9) errf[l] = 1;
        else begin
          open[l] = 1; val[l] = d; cnt[l] = 1;
        end
      end
    end
  endtask

  function automatic exp_t expected(input int l);
    exp_t e;
    e.q    = (hold[l] >= 0) ? (32'd1 << hold[l]) : 32'd0;
    e.qv   = (hold[l] >= 0);
    e.err  = errf[l];
    e.busy = open[l];
    return e;
  endfunction

  task automatic cyc(input bit rst, input bit dv, input int d, input bit cm, input bit clr);
    reset_n        = rst;
    ia.digit_valid = dv;  ib.digit_valid = dv;
    ia.digit       = 4'(d); ib.digit     = 4'(d);
    ia.commit      = cm;  ib.commit      = cm;
    ia.clear       = clr; ib.clear       = clr;
    @(posedge clk);
    #1;
    for (int l = 0; l < 2; l++) step(l, rst, dv, d, cm, clr);
    qa.push_back(expected(0));
    qb.push_back(expected(1));
  endtask

  task automatic dig(input int d); cyc(1, 1, d, 0, 0); endtask
  task automatic com();            cyc(1, 0, 0, 1, 0); endtask
  task automatic idle();           cyc(1, 0, 0, 0, 0); endtask
  task automatic clr();            cyc(1, 0, 0, 0, 1); endtask

  always @(negedge clk) begin
    if (qa.size() > 0) begin
      ea = qa.pop_front();
      chk("a.q", 32'(ia.q), ea.q);
      chk("a.q_valid", 32'(ia.q_valid), 32'(ea.qv));
      chk("a.err", 32'(ia.err), 32'(ea.err));
      chk("a.busy", 32'(ia.busy), 32'(ea.busy));
    end
    if (qb.size() > 0) begin
      eb = qb.pop_front();
      chk("b.q", 32'(ib.q), eb.q);
      chk("b.q_valid", 32'(ib.q_valid), 32'(eb.qv));
      chk("b.err", 32'(ib.err), 32'(eb.err));
      chk("b.busy", 32'(ib.busy), 32'(eb.busy));
    end
  end

  initial begin
    int d;
    bit dv, cm, cl, rs;

    // reset state
    cyc(0, 0, 0, 0, 0);
    chk("rst_q", 32'(ia.q), 0);
    chk("rst_qv", 32'(ia.q_valid), 0);
    chk("rst_err", 32'(ia.err), 0);
    chk("rst_busy", 32'(ia.busy), 0);

    // 1,5 commit -> bit 15, held until clear
    dig(1);
    chk("busy_accum", 32'(ia.busy), 1);
    dig(5); com();
    chk("q15", 32'(ia.q), 32'd1 << 15);
    chk("q15_valid", 32'(ia.q_valid), 1);
    idle(); idle();
    chk("q15_hold", 32'(ia.q), 32'd1 << 15);
    clr();
    chk("clr_q", 32'(ia.q), 0);
    chk("clr_qv", 32'(ia.q_valid), 0);

    // 22 is the top legal code, 23 is out of range
    dig(2); dig(2); com();
    chk("q22", 32'(ia.q), 32'd1 << 22);
    dig(2); dig(3); com();
    chk("q23_err", 32'(ia.err), 1);
    chk("q23_q", 32'(ia.q), 0);
    idle();
    chk("err_after", 32'(ia.err), 32'(STICKY));
    clr();

    // illegal digit in IDLE
    dig(10);
    chk("illegal_err", 32'(ia.err), 1);
    dig(3);
    chk("illegal_after", 32'(ia.err), 32'(STICKY));
    clr();

    // third digit overflows a two-digit code
    dig(1); dig(2); dig(3);
    chk("ovf_err", 32'(ia.err), 1);
    clr();

    // commit beats a same-cycle digit
    dig(4); cyc(1, 1, 5, 1, 0);
    chk("commit_prio", 32'(ia.q), 32'd1 << 4);

    // new frame out of DONE
    dig(7);
    chk("done_new_q", 32'(ia.q), 0);
    chk("done_new_busy", 32'(ia.busy), 1);
    com();
    chk("q7", 32'(ia.q), 32'd1 << 7);

    // reset mid-frame
    dig(1); cyc(0, 0, 0, 0, 0);
    chk("rst_mid_err", 32'(ia.err), 0);
    chk("rst_mid_busy", 32'(ia.busy), 0);
    chk("rst_mid_qv", 32'(ia.q_valid), 0);

    // single-digit decoder top code
    dig(9); com();
    chk("b_q9", 32'(ib.q), 32'd1 << 9);
    chk("a_q9", 32'(ia.q), 32'd1 << 9);
    clr();

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      dv = ($urandom_range(0, 99) < 55);
      d  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(10, 15)) : int'($urandom_range(0, 9));
      cm = ($urandom_range(0, 99) < 22);
      cl = ($urandom_range(0, 99) < 3);
      rs = ($urandom_range(0, 99) >= 2);
      cyc(rs, dv, d, cm, cl);
    end

    idle();
    repeat (2) @(negedge clk);
    chk("drain_a", 32'(qa.size()), 0);
    chk("drain_b", 32'(qb.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
